// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the Harvard MIPS core.
// This covers the PC sequencer states, address width and default vectors.
package mips_cpu_pkg;

  typedef logic [31:0] word_addr_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DELAY  = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

  localparam word_addr_t DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
  localparam word_addr_t DEFAULT_HALT_ADDR    = 32'h0000_0000;

endpackage

// File: rtl/mips_pc_sequencer.sv
// Program counter and run-state controller for the Harvard MIPS core.
// It handles the branch delay slot, clock-enable gating, halt detection and the commit strobe.
module mips_pc_sequencer
  import mips_cpu_pkg::*;
#(
  parameter word_addr_t RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter word_addr_t HALT_ADDR    = DEFAULT_HALT_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] instr_address,
  output logic [31:0] pc_plus4,
  output logic        active,
  output logic        commit,
  output logic        in_delay_slot,
  output logic        fault
);

  pc_state_t  state;
  word_addr_t target_q;
  logic       advance;

  assign advance       = clk_enable & ~stall & ~reset;
  assign commit        = advance & (state != HALTED);
  assign active        = (state != HALTED);
  assign in_delay_slot = (state == DELAY);
  assign pc_plus4      = instr_address + 32'd4;

  // A taken redirect first steps into the delay slot at PC+4.
  // The following advance loads the captured target.
  // If that target is HALT_ADDR, the core parks in HALTED until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_address <= RESET_VECTOR;
      state         <= RUN;
      target_q      <= '0;
      fault         <= 1'b0;
    end else if (advance) begin
      case (state)
        RUN: begin
          instr_address <= pc_plus4;
          if (redirect_valid) begin
            target_q <= {redirect_target[31:2], 2'b00};
            state    <= DELAY;
            if (redirect_target[1:0] != 2'b00)
              fault <= 1'b1;
          end
        end
        DELAY: begin
          instr_address <= target_q;
          state         <= (target_q == HALT_ADDR) ? HALTED : RUN;
          if (redirect_valid)
            fault <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_pc_sequencer.sv
// Directed, table-driven testbench for mips_pc_sequencer.
// Each record holds the inputs for one clock edge and the expected outputs.
module tb_mips_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] instr_address;
  logic [31:0] pc_plus4;
  logic        active;
  logic        commit;
  logic        in_delay_slot;
  logic        fault;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic        rst;
    logic        en;
    logic        stl;
    logic        rv;
    logic [31:0] tgt;
    logic        exp_commit;
    logic [31:0] exp_pc;
    logic        exp_active;
    logic        exp_dly;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[$];

  mips_pc_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .clk_enable     (clk_enable),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .instr_address  (instr_address),
    .pc_plus4       (pc_plus4),
    .active         (active),
    .commit         (commit),
    .in_delay_slot  (in_delay_slot),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic en, input logic stl,
                              input logic rv, input logic [31:0] tgt,
                              input logic ec, input logic [31:0] epc,
                              input logic ea, input logic ed, input logic ef);
    vec_t v;
    v.rst = rst; v.en = en; v.stl = stl; v.rv = rv; v.tgt = tgt;
    v.exp_commit = ec; v.exp_pc = epc; v.exp_active = ea;
    v.exp_dly = ed; v.exp_fault = ef;
    return v;
  endfunction

  task automatic compare(input string name, input int idx,
                         input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL step %0d %s: got %h, expected %h", idx, name, actual, expected);
    end
  endtask

  // Drive the inputs just after an edge, then check commit before the next edge.
  task automatic applyStimulus(input vec_t v, input int idx);
    reset           = v.rst;
    clk_enable      = v.en;
    stall           = v.stl;
    redirect_valid  = v.rv;
    redirect_target = v.tgt;
    #1;
    compare("commit", idx, {31'd0, commit}, {31'd0, v.exp_commit});
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    @(posedge clk);
    #1;
    compare("instr_address", idx, instr_address, v.exp_pc);
    compare("pc_plus4", idx, pc_plus4, v.exp_pc + 32'd4);
    compare("active", idx, {31'd0, active}, {31'd0, v.exp_active});
    compare("in_delay_slot", idx, {31'd0, in_delay_slot}, {31'd0, v.exp_dly});
    compare("fault", idx, {31'd0, fault}, {31'd0, v.exp_fault});
  endtask

  task automatic runVec(input vec_t v, input int idx);
    applyStimulus(v, idx);
    checkOutput(v, idx);
  endtask

  initial begin
    tests_run       = 0;
    tests_failed    = 0;
    reset           = 1'b1;
    clk_enable      = 1'b1;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'd0;

    //               rst en st rv target         commit pc             act dly flt
    // Reset, then sequential fetch.
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,         0, 32'hBFC0_0000, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,         0, 32'hBFC0_0000, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,         1, 32'hBFC0_0004, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,         1, 32'hBFC0_0008, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,         1, 32'hBFC0_000C, 1, 0, 0));
    // Basic branch with its delay slot.
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,         0, 32'hBFC0_0000, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,         1, 32'hBFC0_0004, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 32'hBFC0_0100, 1, 32'hBFC0_0008, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,         1, 32'hBFC0_0100, 1, 0, 0));
    // Move to BFC00010, then stall while a redirect is presented.
    vecs.push_back(mk(0, 1, 0, 1, 32'hBFC0_0010, 1, 32'hBFC0_0104, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,         1, 32'hBFC0_0010, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 32'hBFC0_0200, 0, 32'hBFC0_0010, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 32'hBFC0_0200, 1, 32'hBFC0_0014, 1, 1, 0));
    // Clock enable is low for 5 cycles in DELAY; a redirect here must not set fault.
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 32'hBFC0_0014, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h0000_0000, 0, 32'hBFC0_0014, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 32'hBFC0_0014, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hBFC0_0302, 0, 32'hBFC0_0014, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 32'hBFC0_0014, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,         1, 32'hBFC0_0200, 1, 0, 0));
    // Misaligned target: fault is set and the target is word-aligned.
    vecs.push_back(mk(0, 1, 0, 1, 32'hBFC0_0102, 1, 32'hBFC0_0204, 1, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,         1, 32'hBFC0_0100, 1, 0, 1));
    // Branch in the delay slot is ignored but sets fault.
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,         0, 32'hBFC0_0000, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 32'hBFC0_0300, 1, 32'hBFC0_0004, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1, 32'hBFC0_0400, 1, 32'hBFC0_0300, 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,         1, 32'hBFC0_0304, 1, 0, 1));
    // Halt: the delay slot commits, then everything except reset is ignored.
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,         0, 32'hBFC0_0000, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 32'h0000_0000, 1, 32'hBFC0_0004, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,         1, 32'h0000_0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 32'hBFC0_0101, 0, 32'h0000_0000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 32'h0000_0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,         0, 32'h0000_0000, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,         0, 32'hBFC0_0000, 1, 0, 0));

    @(posedge clk);
    #1;
    foreach (vecs[i]) runVec(vecs[i], i);

    // A reset during DELAY discards the pending target.
    runVec(mk(0, 1, 0, 1, 32'hBFC0_0500, 1, 32'hBFC0_0004, 1, 1, 0), 100);
    runVec(mk(1, 1, 0, 0, 32'h0,         0, 32'hBFC0_0000, 1, 0, 0), 101);
    runVec(mk(0, 1, 0, 0, 32'h0,         1, 32'hBFC0_0004, 1, 0, 0), 102);

    // The PC wraps through zero without halting.
    runVec(mk(0, 1, 0, 1, 32'hFFFF_FFFC, 1, 32'hBFC0_0008, 1, 1, 0), 200);
    runVec(mk(0, 1, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 1, 0, 0), 201);
    compare("wrap pc_plus4", 201, pc_plus4, 32'h0000_0000);
    runVec(mk(0, 1, 0, 0, 32'h0,         1, 32'h0000_0000, 1, 0, 0), 202);
    runVec(mk(0, 1, 0, 0, 32'h0,         1, 32'h0000_0004, 1, 0, 0), 203);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mips_pc_sequencer.md
Name: mips_pc_sequencer

Overview:
Program-counter and run-state controller for the Harvard MIPS core. Owns `instr_address`, the reset vector, MIPS branch-delay-slot sequencing, `clk_enable` gating and halt detection. Drives `active` and a per-cycle `commit` strobe, which gates register-file and data-memory writes in the datapath. Sits between the controlpath (which supplies redirect requests) and the instruction memory port.

Parameters:
RESET_VECTOR, 32'hBFC0_0000, PC value loaded on reset
HALT_ADDR, 32'h0000_0000, jump/branch target that ends execution once its delay slot completes

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset; takes effect on the clock edge regardless of clk_enable
clk_enable  input  1  global advance enable; 0 freezes all state
stall  input  1  hold current instruction (reserved for future memory wait); 0 in current harness
redirect_valid  input  1  instruction at current PC is a taken branch/jump this cycle
redirect_target  input  32  byte address of branch/jump destination
instr_address  output  32  current PC, registered
pc_plus4  output  32  instr_address+4, combinational, for link/branch arithmetic
active  output  1  1 while CPU executing, 0 once halted
commit  output  1  current instruction's architectural writes are permitted this cycle
in_delay_slot  output  1  current instruction is a delay-slot instruction
fault  output  1  sticky error flag

Behaviour:
- Reset values:
  - instr_address=RESET_VECTOR, state=RUN, active=1, in_delay_slot=0, fault=0.
  - Pending target register cleared to 0.
  - pc_plus4=RESET_VECTOR+4.
  - commit is combinational and is not forced during reset.
- Definitions:
  - advance = clk_enable & ~stall & ~reset.
  - commit = advance & (state!=HALTED).
- States: RUN, DELAY, HALTED. active = (state!=HALTED); in_delay_slot = (state==DELAY).
- RUN, on advance:
  - PC <= PC+4.
  - If redirect_valid: target_q <= {redirect_target[31:2],2'b00}, state <= DELAY.
  - If redirect_target[1:0]!=0: fault <= 1, and the target is still used word-aligned.
- DELAY, on advance:
  - PC <= target_q.
  - If target_q==HALT_ADDR: state <= HALTED. Otherwise state <= RUN.
  - redirect_valid in DELAY (branch in delay slot) is ignored and sets fault.
- HALTED:
  - PC holds HALT_ADDR; commit=0; active=0.
  - All inputs except reset are ignored.
  - Only reset leaves HALTED.
- No advance (clk_enable=0 or stall=1): PC, state, target_q and fault all hold. A redirect presented in that cycle is not captured; the controlpath re-presents it because the instruction is unchanged.
- Latency: redirect seen in cycle N (instruction at PC p) gives instr_address=p+4 in N+1 (delay slot), then =target in the next advancing cycle.
- Arithmetic:
  - PC+4 wraps modulo 2^32; 0xFFFF_FFFC -> 0x0000_0000.
  - Sequential arrival at address 0 does NOT halt; only a redirect to HALT_ADDR halts.
- Reset mid-DELAY discards the pending target; execution restarts at RESET_VECTOR.
- fault is cleared only by reset.

Decomposition:
- Shared package mips_cpu_pkg holds:
  - the pc_state_t enum {RUN, DELAY, HALTED};
  - the RESET_VECTOR and HALT_ADDR default constants;
  - a word_addr_t 32-bit typedef.
- Single flat module; no sub-module warranted.
- Top-level mips_cpu_harvard wires active to its port and ANDs RegWrite/data_write with commit.

Test Plan:
- Reset for 2 cycles with clk_enable=1, then release -> instr_address=BFC00000, active=1. After 3 advancing cycles instr_address=BFC0000C, commit=1 each cycle.
- At PC=BFC00004, pulse redirect_valid with target=BFC00100 -> next cycle PC=BFC00008 with in_delay_slot=1, following cycle PC=BFC00100 with in_delay_slot=0.
- Redirect to 00000000 -> delay slot at PC+4 commits, then PC=0, active=0, commit=0. Further redirects and clk_enable toggling leave PC=0. Reset returns PC to BFC00000, active=1.
- clk_enable=0 for 5 cycles in DELAY -> PC, in_delay_slot and target held, commit=0. Re-enable -> PC=target on the first enabled edge.
- stall=1 coincident with redirect_valid at PC=BFC00010 -> no capture, PC holds. Redirect re-presented with stall=0 -> normal delay-slot sequence.
- Errors and wrap:
  - Redirect with target BFC00102 -> fault=1, and after the delay slot PC=BFC00100.
  - Redirect during DELAY -> fault=1, and the redirect is ignored.
  - PC forced to FFFFFFFC via redirect -> next sequential PC=00000000 with active=1.
